// File: rtl/md_pkg.sv
// Shared opcodes, FSM states and helpers for the md_unit multiply/divide block.
// Optional MD_MSUB_EN widens the opcode to 4 bits and adds MSUB/MSUBU.
package md_pkg;

`ifdef MD_MSUB_EN
    localparam int unsigned OP_W = 4;
`else
    localparam int unsigned OP_W = 3;
`endif

    localparam logic [OP_W-1:0] OP_MULT  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(1);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MADD  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_MADDU = OP_W'(7);
`ifdef MD_MSUB_EN
    localparam logic [OP_W-1:0] OP_MSUB  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_MSUBU = OP_W'(9);
`endif

    // Every bit of the quotient is set to this value on a zero divisor.
    localparam bit DIVZ_Q_FILL = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } md_state_e;

    // Busy cycles for a launching opcode; 0 means the op does not occupy the unit.
    function automatic int unsigned md_latency(input logic [OP_W-1:0] op,
                                               input int unsigned mult_cycles,
                                               input int unsigned div_cycles);
        int unsigned lat;
        lat = 0;
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU: lat = mult_cycles;
`ifdef MD_MSUB_EN
            OP_MSUB, OP_MSUBU:                    lat = mult_cycles;
`endif
            OP_DIV, OP_DIVU:                      lat = div_cycles;
            default:                              lat = 0;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result generator for md_unit, including divide corner cases.
// Optional MD_MSUB_EN adds the MSUB/MSUBU subtract-accumulate results.
module md_arith
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic [WIDTH-1:0] d2_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] pending_hi_o,
    output logic [WIDTH-1:0] pending_lo_o
);

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [2*WIDTH-1:0] acc;
    logic               is_sdiv;
    logic               neg1;
    logic               neg2;
    logic               div_zero;
    logic [WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   qmag;
    logic [WIDTH-1:0]   rmag;
    logic [WIDTH-1:0]   q_res;
    logic [WIDTH-1:0]   r_res;

    always_comb begin
        prod_u   = {{WIDTH{1'b0}}, d1_i} * {{WIDTH{1'b0}}, d2_i};
        prod_s   = {{WIDTH{d1_i[WIDTH-1]}}, d1_i} * {{WIDTH{d2_i[WIDTH-1]}}, d2_i};
        acc      = {hi_i, lo_i};

        // One shared unsigned divider; signed division runs on magnitudes.
        // Most-negative / -1 wraps back to most-negative with a zero remainder.
        is_sdiv  = (op_i == OP_DIV);
        neg1     = is_sdiv & d1_i[WIDTH-1];
        neg2     = is_sdiv & d2_i[WIDTH-1];
        div_zero = (d2_i == '0);
        dvd      = neg1 ? -d1_i : d1_i;
        dvs      = neg2 ? -d2_i : d2_i;
        if (div_zero) begin
            dvs = WIDTH'(1);
        end
        qmag     = dvd / dvs;
        rmag     = dvd % dvs;
        q_res    = (neg1 ^ neg2) ? -qmag : qmag;
        r_res    = neg1 ? -rmag : rmag;

        pending_hi_o = hi_i;
        pending_lo_o = lo_i;
        case (op_i)
            OP_MULT:  {pending_hi_o, pending_lo_o} = prod_s;
            OP_MULTU: {pending_hi_o, pending_lo_o} = prod_u;
            OP_MADD:  {pending_hi_o, pending_lo_o} = acc + prod_s;
            OP_MADDU: {pending_hi_o, pending_lo_o} = acc + prod_u;
`ifdef MD_MSUB_EN
            OP_MSUB:  {pending_hi_o, pending_lo_o} = acc - prod_s;
            OP_MSUBU: {pending_hi_o, pending_lo_o} = acc - prod_u;
`endif
            OP_DIV, OP_DIVU: begin
                if (div_zero) begin
                    pending_lo_o = {WIDTH{DIVZ_Q_FILL}};
                    pending_hi_o = d1_i;
                end else begin
                    pending_lo_o = q_res;
                    pending_hi_o = r_res;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO for the EX stage.
// Define MD_MSUB_EN to add MSUB/MSUBU (the op port widens to 4 bits).
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] arith_hi;
    logic [WIDTH-1:0] arith_lo;
    int unsigned      lat;
    logic [CNT_W-1:0] lat_cnt;
    logic             accept;

    md_arith #(
        .WIDTH(WIDTH)
    ) u_arith (
        .op_i        (op),
        .d1_i        (d1),
        .d2_i        (d2),
        .hi_i        (hi_q),
        .lo_i        (lo_q),
        .pending_hi_o(arith_hi),
        .pending_lo_o(arith_lo)
    );

    assign lat     = md_latency(op, MULT_CYCLES, DIV_CYCLES);
    assign lat_cnt = CNT_W'(lat);
    assign accept  = start & ~cancel & (state_q == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op == OP_MTHI) begin
                        hi_d = d1;
                    end else if (op == OP_MTLO) begin
                        lo_d = d1;
                    end else if (lat != 0) begin
                        pend_hi_d = arith_hi;
                        pend_lo_d = arith_lo;
                        cnt_d     = lat_cnt;
                        state_d   = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    pend_hi_d = '0;
                    pend_lo_d = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed, table-driven self-checking bench for md_unit (default 32-bit, 5/10 cycles).
module tb_md_unit;
    import md_pkg::*;

    localparam int unsigned W = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            cancel;
    logic [OP_W-1:0] op;
    logic [W-1:0]    d1;
    logic [W-1:0]    d2;
    logic            busy;
    logic            done;
    logic [W-1:0]    hi;
    logic [W-1:0]    lo;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    md_unit #(
        .WIDTH      (W),
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .d1    (d1),
        .d2    (d2),
        .cancel(cancel),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OP_W-1:0] op;
        logic [W-1:0]    d1;
        logic [W-1:0]    d2;
        logic [W-1:0]    hi;
        logic [W-1:0]    lo;
        int unsigned     lat;
        bit              intrude;
    } vec_t;

    vec_t vecs[17];
    vec_t vtmp;

    task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkn(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called on a falling edge with the unit idle; returns on the falling edge
    // where the result is visible, so the next call starts back-to-back.
    task automatic run_op(input vec_t v, input string name);
        int unsigned nbusy;
        int unsigned ndone;
        int unsigned nstale;
        op = v.op; d1 = v.d1; d2 = v.d2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0; ndone = 0; nstale = 0;
        while (busy === 1'b1 && nbusy < 64) begin
            nbusy++;
            if (done !== 1'b0) ndone++;
            if (hi !== m_hi || lo !== m_lo) nstale++;
            if (v.intrude && nbusy == 1) begin
                start = 1'b1; op = OP_MTLO; d1 = 32'h0BAD0BAD;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checkn({name, ".busy_cycles"}, nbusy, v.lat);
        checkn({name, ".done_while_busy"}, ndone, 0);
        checkn({name, ".hilo_changed_while_busy"}, nstale, 0);
        check1({name, ".done"}, done, v.lat != 0);
        checkw({name, ".hi"}, hi, v.hi);
        checkw({name, ".lo"}, lo, v.lo);
        m_hi = v.hi;
        m_lo = v.lo;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;

        vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5,  1'b0};
        vecs[1]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10, 1'b1};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0};
        vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 1'b0};
        vecs[4]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 10, 1'b0};
        vecs[5]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 10, 1'b0};
        vecs[6]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, 1'b0};
        vecs[7]  = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 10, 1'b0};
        vecs[8]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 10, 1'b0};
        vecs[9]  = '{OP_MTHI,  32'h00001234, 32'h00000000, 32'h00001234, 32'h19999999, 0,  1'b0};
        vecs[10] = '{OP_MTLO,  32'h00005678, 32'h00000000, 32'h00001234, 32'h00005678, 0,  1'b0};
        vecs[11] = '{OP_MADDU, 32'h00000002, 32'h00000003, 32'h00001234, 32'h0000567E, 5,  1'b1};
        vecs[12] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5,  1'b0};
        vecs[13] = '{OP_MADD,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 32'h00000000, 5,  1'b0};
        vecs[14] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5,  1'b0};
        vecs[15] = '{OP_MADD,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 5,  1'b0};
        vecs[16] = '{OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFD, 32'h00000002, 5,  1'b0};

        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = OP_MULT; d1 = '0; d2 = '0;
        repeat (2) @(negedge clk);
        check1("reset.busy", busy, 1'b0);
        check1("reset.done", done, 1'b0);
        checkw("reset.hi", hi, '0);
        checkw("reset.lo", lo, '0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end
        @(negedge clk);
        check1("done_width", done, 1'b0);

        // Cancel mid-multiply with a simultaneous start that must be dropped.
        vtmp = '{OP_MTHI, 32'h0000AAAA, 32'h0, 32'h0000AAAA, m_lo, 0, 1'b0};
        run_op(vtmp, "pre_mthi");
        vtmp = '{OP_MTLO, 32'h0000BBBB, 32'h0, 32'h0000AAAA, 32'h0000BBBB, 0, 1'b0};
        run_op(vtmp, "pre_mtlo");
        op = OP_MULT; d1 = 32'd3; d2 = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check1("cancel.busy_c1", busy, 1'b1);
        repeat (2) @(negedge clk);
        cancel = 1'b1; start = 1'b1; op = OP_MTHI; d1 = 32'h0000DEAD;
        @(negedge clk);
        cancel = 1'b0; start = 1'b0;
        check1("cancel.busy", busy, 1'b0);
        check1("cancel.done", done, 1'b0);
        checkw("cancel.hi", hi, 32'h0000AAAA);
        checkw("cancel.lo", lo, 32'h0000BBBB);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) n++;
        end
        checkn("cancel.quiet_after", n, 0);
        checkw("cancel.hi_after", hi, 32'h0000AAAA);
        checkw("cancel.lo_after", lo, 32'h0000BBBB);

        // Cancel in idle blocks a start and otherwise changes nothing.
        cancel = 1'b1; start = 1'b1; op = OP_MTLO; d1 = 32'h00001111;
        @(negedge clk);
        cancel = 1'b0; start = 1'b0;
        check1("idle_cancel.busy", busy, 1'b0);
        checkw("idle_cancel.lo", lo, 32'h0000BBBB);

        // Asynchronous reset during a divide, then normal recovery.
        op = OP_DIV; d1 = 32'd100; d2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check1("midreset.busy_before", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check1("midreset.busy", busy, 1'b0);
        check1("midreset.done", done, 1'b0);
        checkw("midreset.hi", hi, '0);
        checkw("midreset.lo", lo, '0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        vtmp = '{OP_MULT, 32'd6, 32'd7, 32'h00000000, 32'h0000002A, 5, 1'b0};
        run_op(vtmp, "post_reset_mult");

`ifdef MD_MSUB_EN
        vtmp = '{OP_MSUBU, 32'd2, 32'd3, 32'h00000000, 32'h00000024, 5, 1'b0};
        run_op(vtmp, "msubu");
        vtmp = '{OP_MSUB, 32'hFFFFFFFF, 32'h00000030, 32'h00000000, 32'h00000054, 5, 1'b0};
        run_op(vtmp, "msub");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
